// File: rtl/core3_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// core3_mem_arbiter_if
//
// Bundles the three-requester Avalon-MM style bus and the single-port RAM bus
// that the arbiter sits between.
//
//   Requester side (packed, requester i in slice i):
//     req_read, req_write        per-requester transfer requests
//     req_address                3*ADDR_W packed word addresses
//     req_byteenable             3*DATA_W/8 packed byte enables
//     req_writedata              3*DATA_W packed write data
//     req_waitrequest            per-requester stall (0 = transfer accepted)
//     req_readdata               shared read return data
//     req_readdatavalid          one-hot read return strobe
//   RAM side:
//     mem_address, mem_byteenable, mem_chipselect, mem_write,
//     mem_writedata, mem_clken   driven by the arbiter
//     mem_readdata               RAM output, one clock after the address
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus RAM)
// ----------------------------------------------------------------------------
interface core3_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [2:0]              req_read;
    logic [2:0]              req_write;
    logic [3*ADDR_W-1:0]     req_address;
    logic [3*DATA_W/8-1:0]   req_byteenable;
    logic [3*DATA_W-1:0]     req_writedata;
    logic [2:0]              req_waitrequest;
    logic [DATA_W-1:0]       req_readdata;
    logic [2:0]              req_readdatavalid;

    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W/8-1:0]     mem_byteenable;
    logic                    mem_chipselect;
    logic                    mem_write;
    logic [DATA_W-1:0]       mem_writedata;
    logic                    mem_clken;
    logic [DATA_W-1:0]       mem_readdata;

    modport slave (
        input  req_read, req_write, req_address, req_byteenable, req_writedata,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output req_read, req_write, req_address, req_byteenable, req_writedata,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/core3_mem_arbiter.sv
// ----------------------------------------------------------------------------
// core3_mem_arbiter
//
// Shares one single-port RAM between three requesters. A grant is chosen
// combinationally each cycle by round robin starting after the last granted
// requester, so an accepted transfer reaches the RAM in the same cycle.
// Reads return exactly one cycle after acceptance on a shared data bus with
// a one-hot valid strobe; writes complete in the grant cycle.
//
// Ports:
//   clk    - single clock
//   reset  - asynchronous, active-high
//   bus    - core3_mem_arbiter_if.slave (requester bus and RAM bus)
// ----------------------------------------------------------------------------
module core3_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    core3_mem_arbiter_if.slave   bus
);
    localparam int BE_W = DATA_W / 8;

    logic [2:0] active;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       grant_any;
    logic       accept_read;

    logic [1:0] rr_last;
    logic       rd_valid;
    logic [1:0] rd_id;

    // Reset gates the request vector so no grant can form while reset is held.
    always_comb begin
        active = (bus.req_read | bus.req_write) & {3{~reset}};
    end

    // Search rr_last+1, rr_last+2, rr_last (mod 3); the first active one wins.
    always_comb begin : pick_grant
        logic [2:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= 3; k++) begin
            cand = {1'b0, rr_last} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_any && active[cand[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[1:0];
            end
        end
        if (grant_any) begin
            grant = 3'b001 << grant_idx;
        end
    end

    // Read+write together from one requester is a write, so it gets no return.
    always_comb begin
        accept_read = grant_any && bus.req_read[grant_idx] && !bus.req_write[grant_idx];
    end

    // RAM side mux: the granted slice drives the RAM, otherwise everything is 0.
    always_comb begin
        bus.req_waitrequest = ~grant;
        bus.mem_clken       = ~reset;
        bus.mem_chipselect  = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_byteenable  = '0;
        bus.mem_writedata   = '0;
        if (grant_any) begin
            bus.mem_chipselect = 1'b1;
            bus.mem_write      = bus.req_write[grant_idx];
            bus.mem_address    = bus.req_address[int'(grant_idx)*ADDR_W +: ADDR_W];
            bus.mem_byteenable = bus.req_byteenable[int'(grant_idx)*BE_W +: BE_W];
            bus.mem_writedata  = bus.req_writedata[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    // Round-robin pointer and the one-deep read return tracker. Since RAM
    // latency is fixed at one cycle, a single slot keeps returns in order even
    // with a read accepted every cycle. Reset drops any return in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last  <= 2'd2;
            rd_valid <= 1'b0;
            rd_id    <= 2'd0;
        end else begin
            if (grant_any) begin
                rr_last <= grant_idx;
            end
            rd_valid <= accept_read;
            if (accept_read) begin
                rd_id <= grant_idx;
            end
        end
    end

    // Read return: RAM data is passed through only while a strobe is raised.
    always_comb begin
        bus.req_readdatavalid = '0;
        bus.req_readdata      = '0;
        if (rd_valid) begin
            bus.req_readdatavalid[rd_id] = 1'b1;
            bus.req_readdata             = bus.mem_readdata;
        end
    end
endmodule
